axi_txn_gate: RTL and testbench
===============================

Name: axi_txn_gate

Overview:
- AXI4 (+ATOP) pass-through controller between one upstream manager (slv port) and one downstream subordinate (mst port).
- Limits outstanding read and write transactions to configurable maxima.
- Provides a 4-phase flush/quiesce handshake: stop accepting new AR/AW, drain all in-flight bursts, then acknowledge.
- Sits in front of the memory interconnect; the test-side AXI trace monitor attaches to either port.

Parameters:
- MaxReads, 8, max outstanding AR bursts (≥1); counter width RdCntW = $clog2(MaxReads+1).
- MaxWrites, 8, max outstanding AW bursts (≥1); counter width WrCntW = $clog2(MaxWrites+1).
- axi_req_t, logic, AXI request struct (aw/w/ar payloads, valids, b_ready, r_ready).
- axi_resp_t, logic, AXI response struct (b/r payloads, readies, b_valid, r_valid).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- slv_req_i  in  axi_req_t  upstream request.
- slv_resp_o  out  axi_resp_t  upstream response.
- mst_req_o  out  axi_req_t  downstream request.
- mst_resp_i  in  axi_resp_t  downstream response.
- flush_req_i  in  1  level flush request.
- flush_ack_o  out  1  high in HALTED.
- rd_outstanding_o  out  RdCntW  outstanding read bursts.
- wr_outstanding_o  out  WrCntW  outstanding write bursts (AW accepted, B pending).
- busy_o  out  1  rd or wr outstanding nonzero.

Behaviour:
- Reset values: all counters 0, state RUN, both valid-locks 0, flush_ack_o 0, busy_o 0.
- Payloads and all non-gated valid/ready signals pass combinationally, zero latency. B and R are never gated.
- Handshakes:
  - ar_hs = mst ar_valid & ar_ready.
  - aw_hs = mst aw_valid & aw_ready.
  - r_last_hs = r_valid & r_ready & r.last.
  - b_hs = b_valid & b_ready.
- ar_allow = ar_lock | (state==RUN & rd_cnt < MaxReads).
  - mst ar_valid = slv ar_valid & ar_allow.
  - slv ar_ready = mst ar_ready & ar_allow.
- ar_lock: set when mst ar_valid & !ar_ready; cleared on ar_hs. This keeps a presented valid asserted until handshake (AXI stability), even across a flush.
- AW: aw_allow is identical to ar_allow, using aw_lock, wr_cnt and MaxWrites.
- rd_cnt next = rd_cnt + ar_hs − r_last_hs. Simultaneous events give net 0. No saturation is needed; the assertion checks no overflow above MaxReads and no underflow.
- wr_cnt next = wr_cnt + aw_hs − b_hs. Same assertion rules apply.
- W ordering: wpend counts AWs accepted whose W last has not yet passed (width WrCntW).
  - w_allow = (wpend != 0) | aw_hs. W beats never precede their AW downstream, so drain cannot deadlock.
  - W valid/ready are gated by w_allow.
  - wpend next = wpend + aw_hs − (w_hs & w.last).
- FSM states: RUN, DRAIN, HALTED.
  - RUN → DRAIN when flush_req_i=1.
  - DRAIN → RUN when flush_req_i=0 (aborted flush).
  - DRAIN → HALTED when rd_cnt==0 & wr_cnt==0 & wpend==0 & !ar_lock & !aw_lock & no ar_hs/aw_hs this cycle.
  - HALTED → RUN when flush_req_i=0.
  - flush_ack_o = (state==HALTED), registered.
  - In DRAIN/HALTED, new AR/AW are blocked unless locked.
- A flush asserted in the same cycle as ar_hs: the handshake completes and is counted; it is drained before ack.
- Reset mid-operation returns to reset values immediately. In-flight downstream bursts are the system's responsibility.
- Limit boundary: at rd_cnt==MaxReads, slv ar_ready=0 and mst ar_valid=0, unless a lock is held. A lock cannot coexist with a full count because the lock forms only while allowed.

Decomposition:
- axi_txn_gate_pkg holds the state enum gate_state_e {RUN, DRAIN, HALTED}.
- One sub-module, axi_txn_counter #(MaxCnt), provides an up/down counter with inc_i, dec_i, cnt_o, zero_o, full_o and overflow/underflow assertions. It is instantiated three times: rd, wr, wpend.

Test Plan:
1. MaxReads=2: issue 3 back-to-back ARs with downstream ar_ready=1 and R withheld.
   - Required: 2 ARs pass; the 3rd sees slv ar_ready=0 and rd_outstanding_o=2.
   - After one R with last=1, the 3rd AR passes the next cycle.
2. Same-cycle ar_hs and r_last_hs at rd_cnt=1 → rd_outstanding_o stays 1.
3. W presented before AW: W held with slv w_ready=0 and mst w_valid=0 until the AW handshake. W passes in the AW handshake cycle; 4-beat burst, last clears wpend.
4. Flush with 2 reads and 1 write outstanding: assert flush_req_i.
   - Required: new AR/AW blocked; flush_ack_o rises 1 cycle after the final B/R-last.
   - After flush_req_i drops, state returns to RUN next cycle and ARs pass again.
5. AR valid raised with downstream ar_ready=0, then flush asserted → mst ar_valid stays 1 until ar_ready. That AR is counted and drained before ack.
6. Assert rst_ni=0 asynchronously with rd_cnt=3 in DRAIN → counters 0, state RUN and flush_ack_o 0 without waiting for a clock edge.

Source files
------------

// File: rtl/axi_txn_gate_pkg.sv
// Shared types for the AXI transaction gate: FSM state and default AXI4+ATOP channel structs.
package axi_txn_gate_pkg;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} gate_state_e;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [5:0]       atop;
    } ax_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0] id;
        logic [1:0]     resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } default_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } default_resp_t;

endpackage

// File: rtl/axi_txn_counter.sv
// Up/down occupancy counter; simultaneous inc and dec cancel. Bounds are asserted, not saturated.
module axi_txn_counter #(
    parameter int unsigned MaxCnt = 8,
    parameter int unsigned CntW   = $clog2(MaxCnt + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            zero_o,
    output logic            full_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_o <= '0;
        end else if (inc_i && !dec_i) begin
            cnt_o <= cnt_o + CntW'(1);
        end else if (dec_i && !inc_i) begin
            cnt_o <= cnt_o - CntW'(1);
        end
    end

    assign zero_o = (cnt_o == '0);
    assign full_o = (cnt_o == CntW'(MaxCnt));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc_i && !dec_i && full_o));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && zero_o));

endmodule

// File: rtl/axi_txn_gate.sv
// AXI pass-through that caps outstanding AR/AW bursts, keeps W behind its AW,
// and offers a flush handshake that drains all in-flight traffic before acking.
module axi_txn_gate
    import axi_txn_gate_pkg::*;
#(
    parameter int unsigned MaxReads  = 8,
    parameter int unsigned MaxWrites = 8,
    parameter type axi_req_t  = axi_txn_gate_pkg::default_req_t,
    parameter type axi_resp_t = axi_txn_gate_pkg::default_resp_t,
    localparam int unsigned RdCntW = $clog2(MaxReads + 1),
    localparam int unsigned WrCntW = $clog2(MaxWrites + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  axi_req_t          slv_req_i,
    output axi_resp_t         slv_resp_o,
    output axi_req_t          mst_req_o,
    input  axi_resp_t         mst_resp_i,
    input  logic              flush_req_i,
    output logic              flush_ack_o,
    output logic [RdCntW-1:0] rd_outstanding_o,
    output logic [WrCntW-1:0] wr_outstanding_o,
    output logic              busy_o
);

    gate_state_e state_q, state_d;
    logic ar_lock_q, aw_lock_q;
    logic ar_allow, aw_allow, w_allow;
    logic mst_ar_valid, mst_aw_valid, mst_w_valid;
    logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;
    logic rd_zero, rd_full, wr_zero, wr_full, wp_zero, wp_full;
    logic drained;
    logic [WrCntW-1:0] wpend;

    // A lock only forms while allowed, so it overrides both the limit and the flush block.
    assign ar_allow = ar_lock_q | ((state_q == RUN) & !rd_full);
    assign aw_allow = aw_lock_q | ((state_q == RUN) & !wr_full);

    assign mst_ar_valid = slv_req_i.ar_valid & ar_allow;
    assign mst_aw_valid = slv_req_i.aw_valid & aw_allow;
    assign ar_hs        = mst_ar_valid & mst_resp_i.ar_ready;
    assign aw_hs        = mst_aw_valid & mst_resp_i.aw_ready;

    // W may ride along in its own AW handshake cycle, but never ahead of it.
    assign w_allow     = !wp_zero | aw_hs;
    assign mst_w_valid = slv_req_i.w_valid & w_allow;
    assign w_last_hs   = mst_w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
    assign r_last_hs   = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign b_hs        = mst_resp_i.b_valid & slv_req_i.b_ready;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.ar_valid = mst_ar_valid;
        mst_req_o.aw_valid = mst_aw_valid;
        mst_req_o.w_valid  = mst_w_valid;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_allow;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_lock_q <= 1'b0;
            aw_lock_q <= 1'b0;
            state_q   <= RUN;
        end else begin
            ar_lock_q <= mst_ar_valid & !mst_resp_i.ar_ready;
            aw_lock_q <= mst_aw_valid & !mst_resp_i.aw_ready;
            state_q   <= state_d;
        end
    end

    assign drained = rd_zero & wr_zero & wp_zero & !ar_lock_q & !aw_lock_q & !ar_hs & !aw_hs;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req_i) state_d = DRAIN;
            DRAIN:   if (!flush_req_i) state_d = RUN;
                     else if (drained) state_d = HALTED;
            HALTED:  if (!flush_req_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign flush_ack_o = (state_q == HALTED);
    assign busy_o      = !rd_zero | !wr_zero;

    axi_txn_counter #(.MaxCnt(MaxReads), .CntW(RdCntW)) i_rd_cnt (
        .clk_i, .rst_ni, .inc_i(ar_hs), .dec_i(r_last_hs),
        .cnt_o(rd_outstanding_o), .zero_o(rd_zero), .full_o(rd_full)
    );

    axi_txn_counter #(.MaxCnt(MaxWrites), .CntW(WrCntW)) i_wr_cnt (
        .clk_i, .rst_ni, .inc_i(aw_hs), .dec_i(b_hs),
        .cnt_o(wr_outstanding_o), .zero_o(wr_zero), .full_o(wr_full)
    );

    axi_txn_counter #(.MaxCnt(MaxWrites), .CntW(WrCntW)) i_wpend_cnt (
        .clk_i, .rst_ni, .inc_i(aw_hs), .dec_i(w_last_hs),
        .cnt_o(wpend), .zero_o(wp_zero), .full_o(wp_full)
    );

    // Every AW still waiting on W data also has its B pending.
    a_wpend_le_wr: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wp_full |-> !wr_zero);

endmodule

// File: tb/tb_axi_txn_gate.sv
// Directed bench for axi_txn_gate: limits, W ordering, flush handshake, locks and async reset.
module tb_axi_txn_gate;
    import axi_txn_gate_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    default_req_t  req, mreq, mreq3;
    default_resp_t resp, sresp, sresp3;
    logic ack, ack3, busy, busy3;
    logic [1:0] rd, wr;
    logic [2:0] rd3, wr3;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_txn_gate #(.MaxReads(2), .MaxWrites(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req), .slv_resp_o(sresp),
        .mst_req_o(mreq), .mst_resp_i(resp), .flush_req_i(flush), .flush_ack_o(ack),
        .rd_outstanding_o(rd), .wr_outstanding_o(wr), .busy_o(busy)
    );

    // Deeper instance sharing the stimulus, used where a count of 3 is needed.
    axi_txn_gate #(.MaxReads(4), .MaxWrites(4)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req), .slv_resp_o(sresp3),
        .mst_req_o(mreq3), .mst_resp_i(resp), .flush_req_i(flush), .flush_ack_o(ack3),
        .rd_outstanding_o(rd3), .wr_outstanding_o(wr3), .busy_o(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        resp  = '0;
        flush = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        req  = '0;
        resp = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd",   32'(rd),   32'd0);
        chk("rst_wr",   32'(wr),   32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack",  32'(ack),  32'd0);
        #5 rst_n = 1'b1;
        tick();

        // 1: limit of 2 reads, third AR waits for an R last
        req.ar_valid = 1'b1; req.ar.addr = 32'h1234_5678; resp.ar_ready = 1'b1;
        #1;
        chk("t1_ar0_rdy", 32'(sresp.ar_ready), 32'd1);
        chk("t1_addr",    32'(mreq.ar.addr),   32'h1234_5678);
        tick();
        chk("t1_cnt1", 32'(rd), 32'd1);
        tick();
        chk("t1_cnt2",    32'(rd),             32'd2);
        chk("t1_ar2_rdy", 32'(sresp.ar_ready), 32'd0);
        chk("t1_ar2_vld", 32'(mreq.ar_valid),  32'd0);
        resp.r_valid = 1'b1; resp.r.last = 1'b1; resp.r.data = 32'hcafe; req.r_ready = 1'b1;
        #1;
        chk("t1_rdata", 32'(sresp.r.data), 32'hcafe);
        tick();
        resp.r_valid = 1'b0;
        #1;
        chk("t1_cnt_after_r", 32'(rd),             32'd1);
        chk("t1_ar2_pass",    32'(sresp.ar_ready), 32'd1);
        tick();
        chk("t1_cnt_refill", 32'(rd), 32'd2);
        req.ar_valid = 1'b0;

        // 2: simultaneous AR and R last at count 1
        resp.r_valid = 1'b1;
        tick();
        chk("t2_pre", 32'(rd), 32'd1);
        req.ar_valid = 1'b1;
        tick();
        chk("t2_net0", 32'(rd), 32'd1);
        req.ar_valid = 1'b0;
        tick();
        resp.r_valid = 1'b0;
        chk("t2_rd0",   32'(rd),   32'd0);
        chk("t2_busy0", 32'(busy), 32'd0);

        // 3: W before AW is held, then a 4-beat burst
        do_reset();
        req.w_valid = 1'b1; req.w.last = 1'b0; resp.w_ready = 1'b1; resp.aw_ready = 1'b1;
        #1;
        chk("t3_w_blk_rdy", 32'(sresp.w_ready), 32'd0);
        chk("t3_w_blk_vld", 32'(mreq.w_valid),  32'd0);
        tick();
        chk("t3_w_blk2", 32'(mreq.w_valid), 32'd0);
        req.aw_valid = 1'b1;
        #1;
        chk("t3_w_aw_vld", 32'(mreq.w_valid),  32'd1);
        chk("t3_w_aw_rdy", 32'(sresp.w_ready), 32'd1);
        tick();
        req.aw_valid = 1'b0;
        #1;
        chk("t3_wr1",   32'(wr),           32'd1);
        chk("t3_beat1", 32'(mreq.w_valid), 32'd1);
        tick();
        tick();
        req.w.last = 1'b1;
        tick();
        chk("t3_w_blk_after", 32'(mreq.w_valid), 32'd0);
        chk("t3_wr_still1",   32'(wr),           32'd1);
        req.w_valid = 1'b0; resp.b_valid = 1'b1; req.b_ready = 1'b1;
        tick();
        resp.b_valid = 1'b0;
        chk("t3_wr0", 32'(wr), 32'd0);

        // 4: flush with 2 reads and 1 write outstanding
        do_reset();
        req.ar_valid = 1'b1; resp.ar_ready = 1'b1;
        req.aw_valid = 1'b1; resp.aw_ready = 1'b1;
        req.w_valid = 1'b1; req.w.last = 1'b1; resp.w_ready = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        tick();
        req.ar_valid = 1'b0;
        chk("t4_rd2", 32'(rd), 32'd2);
        chk("t4_wr1", 32'(wr), 32'd1);
        flush = 1'b1;
        tick();
        resp.b_valid = 1'b1; req.b_ready = 1'b1;
        tick();
        resp.b_valid = 1'b0;
        chk("t4_wr0", 32'(wr), 32'd0);
        req.aw_valid = 1'b1;
        #1;
        chk("t4_aw_blk", 32'(mreq.aw_valid),  32'd0);
        chk("t4_aw_rdy", 32'(sresp.aw_ready), 32'd0);
        resp.r_valid = 1'b1; resp.r.last = 1'b1; req.r_ready = 1'b1;
        tick();
        resp.r_valid = 1'b0;
        req.ar_valid = 1'b1;
        #1;
        chk("t4_ar_blk", 32'(mreq.ar_valid), 32'd0);
        resp.r_valid = 1'b1;
        tick();
        resp.r_valid = 1'b0;
        chk("t4_rd0",     32'(rd),  32'd0);
        chk("t4_ack_pre", 32'(ack), 32'd0);
        tick();
        chk("t4_ack", 32'(ack), 32'd1);
        flush = 1'b0;
        #1;
        chk("t4_halt_blk", 32'(mreq.ar_valid), 32'd0);
        tick();
        chk("t4_ack_drop", 32'(ack),           32'd0);
        chk("t4_run_ar",   32'(mreq.ar_valid), 32'd1);

        // 5: locked AR survives a flush and is drained before ack
        do_reset();
        req.ar_valid = 1'b1; resp.ar_ready = 1'b0;
        #1;
        chk("t5_vld", 32'(mreq.ar_valid), 32'd1);
        tick();
        flush = 1'b1;
        tick();
        chk("t5_lock_vld", 32'(mreq.ar_valid),  32'd1);
        chk("t5_rdy0",     32'(sresp.ar_ready), 32'd0);
        tick();
        chk("t5_ack_lock", 32'(ack), 32'd0);
        resp.ar_ready = 1'b1;
        #1;
        chk("t5_rdy", 32'(sresp.ar_ready), 32'd1);
        tick();
        req.ar_valid = 1'b0;
        chk("t5_cnt", 32'(rd), 32'd1);
        tick();
        chk("t5_ack_wait", 32'(ack), 32'd0);
        resp.r_valid = 1'b1; resp.r.last = 1'b1; req.r_ready = 1'b1;
        tick();
        resp.r_valid = 1'b0;
        chk("t5_rd0",     32'(rd),  32'd0);
        chk("t5_ack_pre", 32'(ack), 32'd0);
        tick();
        chk("t5_ack", 32'(ack), 32'd1);

        // 6: asynchronous reset in DRAIN with 3 reads outstanding
        do_reset();
        req.ar_valid = 1'b1; resp.ar_ready = 1'b1;
        tick();
        tick();
        tick();
        req.ar_valid = 1'b0;
        chk("t6_rd3",   32'(rd3), 32'd3);
        chk("t6_rd_lim", 32'(rd), 32'd2);
        flush = 1'b1;
        tick();
        chk("t6_busy", 32'(busy3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_rd",   32'(rd3),   32'd0);
        chk("t6_async_busy", 32'(busy3), 32'd0);
        chk("t6_async_ack",  32'(ack3),  32'd0);
        chk("t6_async_rd2",  32'(rd),    32'd0);
        flush = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        req.ar_valid = 1'b1;
        #1;
        chk("t6_run", 32'(mreq3.ar_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
